// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one sequence_detect between 2**ID_W requesters; counts z hits per frame.
// Optional SEQ_SCHED_FIXED_PRI_EN: lowest-index fixed priority instead of round-robin.
module seq_detect_sched #(
  parameter int ID_W    = 2,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2**ID_W-1:0]         req,
  input  logic [2**ID_W*FRAME_W-1:0] frame_data,
  input  logic [2**ID_W*CNT_W-1:0]   frame_len,
  output logic [2**ID_W-1:0]         gnt,
  output logic                       busy,
  output logic                       det_rst,
  output logic                       det_x,
  input  logic                       det_z,
  output logic                       done,
  output logic [ID_W-1:0]            done_id,
  output logic [CNT_W-1:0]           hit_cnt
);

  localparam int N_REQ = 2**ID_W;
  localparam logic [N_REQ-1:0] GNT_ONE = 1;

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] sreg;
  logic [CNT_W-1:0]   bit_cnt, hit, hit_nxt, sel_len, eff_len;
  logic [ID_W-1:0]    win_id, win_sel, cand, search_base;
  logic               win_vld, hit_inc;

`ifdef SEQ_SCHED_FIXED_PRI_EN
  assign search_base = '0;
`else
  logic [ID_W-1:0] rr_ptr;
  assign search_base = rr_ptr;
`endif

  // Search wraps naturally because N_REQ is a power of two.
  always_comb begin
    win_vld = 1'b0;
    win_sel = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = search_base + ID_W'(k);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_sel = cand;
      end
    end
  end

  assign sel_len = frame_len[win_sel*CNT_W +: CNT_W];
  assign eff_len = (sel_len == '0 || sel_len > CNT_W'(FRAME_W)) ? CNT_W'(FRAME_W) : sel_len;

  assign hit_inc = (state == SHIFT || state == DRAIN) && det_z && (hit != '1);
  assign hit_nxt = hit + CNT_W'(hit_inc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // bit_cnt holds the number of bits still to be emitted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = CLR;
      CLR:     state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == '0) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg    <= '0;
      bit_cnt <= '0;
      hit     <= '0;
      win_id  <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      det_rst <= 1'b0;
      det_x   <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      hit_cnt <= '0;
`ifndef SEQ_SCHED_FIXED_PRI_EN
      rr_ptr  <= '0;
`endif
    end else begin
      busy    <= (state_nxt != IDLE);
      det_rst <= (state_nxt == CLR);
      done    <= (state_nxt == DONE);

      if (state_nxt == SHIFT) begin
        det_x   <= sreg[FRAME_W-1];
        sreg    <= sreg << 1;
        bit_cnt <= bit_cnt - CNT_W'(1);
      end else begin
        det_x   <= 1'b0;
      end

      case (state)
        IDLE: if (win_vld) begin
          sreg    <= frame_data[win_sel*FRAME_W +: FRAME_W];
          bit_cnt <= eff_len;
          win_id  <= win_sel;
          gnt     <= GNT_ONE << win_sel;
        end
        CLR:   hit <= '0;
        SHIFT: hit <= hit_nxt;
        DRAIN: begin
          hit     <= hit_nxt;
          hit_cnt <= hit_nxt;
          done_id <= win_id;
        end
        DONE: begin
          gnt    <= '0;
`ifndef SEQ_SCHED_FIXED_PRI_EN
          rr_ptr <= win_id + ID_W'(1);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched with a one-cycle-delay detector stub.
module tb_seq_detect_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] frame_data = '0;
  logic [15:0] frame_len = '0;
  logic [3:0]  gnt;
  logic        busy, det_rst, det_x, det_z, done;
  logic [1:0]  done_id;
  logic [3:0]  hit_cnt;

  int total = 0;
  int bad = 0;
  int dones = 0;
  int exp_q[$];
  int e;

  always #5 clk = ~clk;

  seq_detect_sched #(.ID_W(2), .FRAME_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .frame_data(frame_data), .frame_len(frame_len),
    .gnt(gnt), .busy(busy), .det_rst(det_rst), .det_x(det_x), .det_z(det_z),
    .done(done), .done_id(done_id), .hit_cnt(hit_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       det_z <= 1'b0;
    else if (det_rst) det_z <= 1'b0;
    else              det_z <= det_x;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_hits(input logic [7:0] d, input logic [3:0] l);
    int n = (l == 0 || l > 8) ? 8 : int'(l);
    int h = 0;
    for (int i = 0; i < n; i++) h += int'(d[7-i]);
    return h;
  endfunction

  task automatic set_frame(input int id, input logic [7:0] d, input logic [3:0] l);
    frame_data[id*8 +: 8] = d;
    frame_len[id*4 +: 4]  = l;
  endtask

  task automatic push_exp(input int id, input logic [7:0] d, input logic [3:0] l);
    exp_q.push_back(id*16 + exp_hits(d, l));
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n = 0;
    while (dones < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_wait", dones, target);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      dones++;
      chk("q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("done_id", done_id, e / 16);
        chk("hit_cnt", hit_cnt, e % 16);
      end
    end
  end

  initial begin
    int cyc;
    int nfr;
    logic [7:0] pat;

    // Reset held with all requests high
    reset = 1'b0;
    req = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_det_rst", det_rst, 0);
    chk("rst_det_x", det_x, 0);
    chk("rst_done", done, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_done_id", done_id, 0);
    req = '0;
    reset = 1'b1;
    @(negedge clk);

    // Single frame, requester 0, B0 len 4
    set_frame(0, 8'hB0, 4'd4);
    push_exp(0, 8'hB0, 4'd4);
    req = 4'b0001;
    @(negedge clk);
    chk("c1_det_rst", det_rst, 1);
    chk("c1_gnt", gnt, 4'b0001);
    chk("c1_busy", busy, 1);
    chk("c1_det_x", det_x, 0);
    req = '0;
    pat = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("single_det_x", det_x, pat[7-i]);
    end
    @(negedge clk);
    chk("drain_det_x", det_x, 0);
    chk("drain_done", done, 0);
    @(negedge clk);
    chk("c7_done", done, 1);
    @(negedge clk);
    chk("c8_busy", busy, 0);
    chk("c8_gnt", gnt, 0);
    chk("single_count", dones, 1);

    // All four requests held continuously
    do_reset();
    set_frame(0, 8'h00, 4'd3);
    set_frame(1, 8'h80, 4'd3);
    set_frame(2, 8'hA0, 4'd3);
    set_frame(3, 8'hE0, 4'd3);
`ifdef SEQ_SCHED_FIXED_PRI_EN
    nfr = 3;
    for (int i = 0; i < 3; i++) push_exp(0, 8'h00, 4'd3);
`else
    nfr = 5;
    push_exp(0, 8'h00, 4'd3);
    push_exp(1, 8'h80, 4'd3);
    push_exp(2, 8'hA0, 4'd3);
    push_exp(3, 8'hE0, 4'd3);
    push_exp(0, 8'h00, 4'd3);
`endif
    req = 4'hF;
    wait_dones(dones + nfr, nfr * 7 + 10);
    req = '0;
    repeat (2) @(negedge clk);

    // Length boundaries: 0 and 9 both mean 8 bits
    for (int t = 0; t < 2; t++) begin
      set_frame(2, 8'hFF, (t == 0) ? 4'd0 : 4'd9);
      exp_q.push_back(2*16 + 8);
      req = 4'b0100;
      cyc = 0;
      while (!done && cyc < 30) begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) req = '0;
      end
      chk((t == 0) ? "len0_done_cycle" : "len9_done_cycle", cyc, 11);
      @(negedge clk);
    end

    // Data change after grant is ignored
    set_frame(1, 8'hA5, 4'd8);
    exp_q.push_back(1*16 + 4);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    pat = 8'b10100101;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("latched_det_x", det_x, pat[7-i]);
      if (i == 1) frame_data[15:8] = 8'h00;
    end
    wait_dones(dones + 1, 10);
    @(negedge clk);

    // Asynchronous reset mid-frame
    set_frame(0, 8'hFF, 4'd8);
    req = 4'b0001;
    repeat (4) @(negedge clk);
    req = '0;
    chk("pre_abort_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("abort_gnt", gnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_det_x", det_x, 0);
    chk("abort_det_rst", det_rst, 0);
    chk("abort_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Pointer restarted at 0: requester 1 wins before 3
    set_frame(1, 8'hC0, 4'd2);
    set_frame(3, 8'h80, 4'd1);
    push_exp(1, 8'hC0, 4'd2);
    push_exp(3, 8'h80, 4'd1);
    req = 4'b1010;
    wait_dones(dones + 1, 15);
    req[1] = 1'b0;
    wait_dones(dones + 1, 15);
    req = '0;
    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
